// File: rtl/s_axi_read_pkg.sv
// rtl/s_axi_read_pkg.sv - shared address map, response codes and FSM encodings for the AXI-Lite slaves
// Purpose: constants shared by s_axi_read and s_axi_write so both decode
//          the register file identically.
// Contents: bank select codes, bank0 register offsets, bank1 field offsets,
//           RRESP/BRESP codes, read FSM state type.
package s_axi_read_pkg;

  // ARADDR[15:14] selects the bank
  localparam logic [1:0] BANK_SEL_0 = 2'b00;
  localparam logic [1:0] BANK_SEL_1 = 2'b01;

  // bank0 register offsets, ARADDR[13:6]
  localparam logic [7:0] B0_CONTROL       = 8'h00;
  localparam logic [7:0] B0_STATUS        = 8'h01;
  localparam logic [7:0] B0_CUR_CNT       = 8'h02;
  localparam logic [7:0] B0_END_CNT       = 8'h03;
  localparam logic [7:0] B0_DMA_BASE_ADDR = 8'h04;
  localparam logic [7:0] B0_DFX_CTRL_ADDR = 8'h05;

  // bank1 slot field offsets, ARADDR[5:2]
  localparam logic [3:0] B1_SRC_ADDR         = 4'h0;
  localparam logic [3:0] B1_SRC_SIZE         = 4'h1;
  localparam logic [3:0] B1_DES_ADDR         = 4'h2;
  localparam logic [3:0] B1_DES_SIZE         = 4'h3;
  localparam logic [3:0] B1_STATUS           = 4'h4;
  localparam logic [3:0] B1_PROFILE          = 4'h5;
  localparam logic [3:0] B1_LD_MASK          = 4'h6;
  localparam logic [3:0] B1_ST_MASK          = 4'h7;
  localparam logic [3:0] B1_ST_INTR_MASK_ABS = 4'h8;

  // RRESP / BRESP
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_RESP  = 2'b10
  } rd_state_t;

endpackage

// File: rtl/s_axi_read_mux.sv
// rtl/s_axi_read_mux.sv - combinational address decode and zero-extend of register file fields
// Purpose: select one bank0 register or bank1 slot field by address and
//          widen/narrow it to DATA_WIDTH; unmapped addresses give 0/SLVERR.
// Ports:   addr           latched read address
//          b0_*/b1_*      bank field values (bank1 already indexed by slot)
//          data, resp     selected value and response code
module s_axi_read_mux
  import s_axi_read_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK1_LD_MSK_WIDTH   = 8,
  parameter int BANK1_ST_MSK_WIDTH   = 8,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = 3
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  b0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   b0_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      b0_cur_cnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      b0_end_cnt,
  input  logic [GLOB_ADDR_WIDTH-1:0]      b0_dma_base_addr,
  input  logic [GLOB_ADDR_WIDTH-1:0]      b0_dfx_ctrl_addr,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] b1_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] b1_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] b1_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] b1_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   b1_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  b1_profile,
  input  logic [BANK1_LD_MSK_WIDTH-1:0]   b1_ld_mask,
  input  logic [BANK1_ST_MSK_WIDTH-1:0]   b1_st_mask,
  input  logic [BANK1_ST_MSK_WIDTH-1:0]   b1_st_intr_mask_abs,
  output logic [DATA_WIDTH-1:0]           data,
  output logic [1:0]                      resp
);

  // byte-lane bits carry no register selection
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // size casts zero-extend narrow fields and keep the LSBs of wide ones
  always_comb begin
    data = '0;
    resp = RESP_SLVERR;
    case (addr[15:14])
      BANK_SEL_0: begin
        resp = RESP_OKAY;
        case (addr[13:6])
          B0_CONTROL:       data = DATA_WIDTH'(b0_control);
          B0_STATUS:        data = DATA_WIDTH'(b0_status);
          B0_CUR_CNT:       data = DATA_WIDTH'(b0_cur_cnt);
          B0_END_CNT:       data = DATA_WIDTH'(b0_end_cnt);
          B0_DMA_BASE_ADDR: data = DATA_WIDTH'(b0_dma_base_addr);
          B0_DFX_CTRL_ADDR: data = DATA_WIDTH'(b0_dfx_ctrl_addr);
          default:          resp = RESP_SLVERR;
        endcase
      end
      BANK_SEL_1: begin
        resp = RESP_OKAY;
        case (addr[5:2])
          B1_SRC_ADDR:         data = DATA_WIDTH'(b1_src_addr);
          B1_SRC_SIZE:         data = DATA_WIDTH'(b1_src_size);
          B1_DES_ADDR:         data = DATA_WIDTH'(b1_des_addr);
          B1_DES_SIZE:         data = DATA_WIDTH'(b1_des_size);
          B1_STATUS:           data = DATA_WIDTH'(b1_status);
          B1_PROFILE:          data = DATA_WIDTH'(b1_profile);
          B1_LD_MASK:          data = DATA_WIDTH'(b1_ld_mask);
          B1_ST_MASK:          data = DATA_WIDTH'(b1_st_mask);
          B1_ST_INTR_MASK_ABS: data = DATA_WIDTH'(b1_st_intr_mask_abs);
          default:             resp = RESP_SLVERR;
        endcase
      end
      default: begin
        data = '0;
        resp = RESP_SLVERR;
      end
    endcase
  end

endmodule

// File: rtl/s_axi_read.sv
// rtl/s_axi_read.sv - AXI-Lite read slave for the DFX sequencer register file
// Purpose: accept one AR at a time, latch the address, give bank1 a cycle to
//          settle on the slot index, register the decoded value and return it on R.
// Ports:   clk, reset (async, active-high)
//          S_AXI_AR*  read address channel;  S_AXI_R*  read data channel
//          ext_bank1_rd_index  slot row driven to bank1 from the latched address
//          ext_bank1_rd_*      bank1 fields of the indexed row
//          ext_bank0_rd_*      bank0 registers
module s_axi_read
  import s_axi_read_pkg::*;
#(
  parameter int GLOB_ADDR_WIDTH      = 32,
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_INDEX_WIDTH    = 3,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK1_LD_MSK_WIDTH   = 8,
  parameter int BANK1_ST_MSK_WIDTH   = 8,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_rd_index,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_rd_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_rd_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_rd_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_rd_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_rd_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_rd_profile,
  input  logic [BANK1_LD_MSK_WIDTH-1:0]   ext_bank1_rd_ld_mask,
  input  logic [BANK1_ST_MSK_WIDTH-1:0]   ext_bank1_rd_st_mask,
  input  logic [BANK1_ST_MSK_WIDTH-1:0]   ext_bank1_rd_st_intr_mask_abs,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  ext_bank0_rd_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_rd_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_rd_curCnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_rd_endCnt,
  input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_rd_dmaBaseAddr,
  input  logic [GLOB_ADDR_WIDTH-1:0]      ext_bank0_rd_dfxCtrlAddr
);

  rd_state_t               state, next_state;
  logic [ADDR_WIDTH-1:0]   read_addr;
  logic                    latch_addr;
  logic                    load_data;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic [1:0]              mux_resp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_addr = 1'b0;
    load_data  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (S_AXI_ARVALID) begin
          next_state = ST_FETCH;
          latch_addr = 1'b1;
        end
      end
      // bank1 sees the new index during this whole cycle before we sample it
      ST_FETCH: begin
        next_state = ST_RESP;
        load_data  = 1'b1;
      end
      ST_RESP: begin
        if (S_AXI_RREADY) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr   <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      if (latch_addr) read_addr <= S_AXI_ARADDR;
      // captured once; banks are not re-sampled while RESP is held
      if (load_data) begin
        S_AXI_RDATA <= mux_data;
        S_AXI_RRESP <= mux_resp;
      end
    end
  end

  assign S_AXI_ARREADY      = (state == ST_IDLE);
  assign S_AXI_RVALID       = (state == ST_RESP);
  // upper index bits within [13:6] are dropped, so slots alias
  assign ext_bank1_rd_index = read_addr[BANK1_INDEX_WIDTH+5:6];

  s_axi_read_mux #(
    .GLOB_ADDR_WIDTH      (GLOB_ADDR_WIDTH),
    .ADDR_WIDTH           (ADDR_WIDTH),
    .DATA_WIDTH           (DATA_WIDTH),
    .BANK1_SRC_ADDR_WIDTH (BANK1_SRC_ADDR_WIDTH),
    .BANK1_SRC_SIZE_WIDTH (BANK1_SRC_SIZE_WIDTH),
    .BANK1_DST_ADDR_WIDTH (BANK1_DST_ADDR_WIDTH),
    .BANK1_DST_SIZE_WIDTH (BANK1_DST_SIZE_WIDTH),
    .BANK1_STATUS_WIDTH   (BANK1_STATUS_WIDTH),
    .BANK1_PROFILE_WIDTH  (BANK1_PROFILE_WIDTH),
    .BANK1_LD_MSK_WIDTH   (BANK1_LD_MSK_WIDTH),
    .BANK1_ST_MSK_WIDTH   (BANK1_ST_MSK_WIDTH),
    .BANK0_CONTROL_WIDTH  (BANK0_CONTROL_WIDTH),
    .BANK0_STATUS_WIDTH   (BANK0_STATUS_WIDTH),
    .BANK0_CNT_WIDTH      (BANK0_CNT_WIDTH)
  ) u_mux (
    .addr                (read_addr),
    .b0_control          (ext_bank0_rd_control),
    .b0_status           (ext_bank0_rd_status),
    .b0_cur_cnt          (ext_bank0_rd_curCnt),
    .b0_end_cnt          (ext_bank0_rd_endCnt),
    .b0_dma_base_addr    (ext_bank0_rd_dmaBaseAddr),
    .b0_dfx_ctrl_addr    (ext_bank0_rd_dfxCtrlAddr),
    .b1_src_addr         (ext_bank1_rd_src_addr),
    .b1_src_size         (ext_bank1_rd_src_size),
    .b1_des_addr         (ext_bank1_rd_des_addr),
    .b1_des_size         (ext_bank1_rd_des_size),
    .b1_status           (ext_bank1_rd_status),
    .b1_profile          (ext_bank1_rd_profile),
    .b1_ld_mask          (ext_bank1_rd_ld_mask),
    .b1_st_mask          (ext_bank1_rd_st_mask),
    .b1_st_intr_mask_abs (ext_bank1_rd_st_intr_mask_abs),
    .data                (mux_data),
    .resp                (mux_resp)
  );

endmodule

// File: tb/tb_s_axi_read.sv
// tb/tb_s_axi_read.sv - directed self-checking bench for s_axi_read
module tb_s_axi_read;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [2:0]  b1_index;
  logic [31:0] b1_src_addr;
  logic [25:0] b1_src_size;
  logic [31:0] b1_des_addr;
  logic [25:0] b1_des_size;
  logic [1:0]  b1_status;
  logic [31:0] b1_profile;
  logic [7:0]  b1_ld_mask;
  logic [7:0]  b1_st_mask;
  logic [7:0]  b1_st_intr;
  logic [3:0]  b0_control = 4'hA;
  logic [3:0]  b0_status = 4'hC;
  logic [2:0]  b0_cur_cnt = 3'h2;
  logic [2:0]  b0_end_cnt = 3'h6;
  logic [31:0] b0_dma = 32'hA000_1000;
  logic [31:0] b0_dfx = 32'h5555_AAAA;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // bank1 storage model: every field depends on the slot index
  always_comb begin
    b1_src_addr = 32'h2000_0000 | 32'(b1_index);
    b1_src_size = 26'h3FF_FFF0 | 26'(b1_index);
    b1_des_addr = 32'h3000_0000 | 32'(b1_index);
    b1_des_size = 26'h000_0100 | 26'(b1_index);
    b1_status   = b1_index[1:0];
    b1_profile  = (b1_index == 3'd5) ? 32'h0000_BEEF : (32'h1000_0000 | 32'(b1_index));
    b1_ld_mask  = 8'h40 | 8'(b1_index);
    b1_st_mask  = 8'h60 | 8'(b1_index);
    b1_st_intr  = 8'h80 | 8'(b1_index);
  end

  s_axi_read dut (
    .clk                           (clk),
    .reset                         (reset),
    .S_AXI_ARADDR                  (araddr),
    .S_AXI_ARVALID                 (arvalid),
    .S_AXI_ARREADY                 (arready),
    .S_AXI_RDATA                   (rdata),
    .S_AXI_RRESP                   (rresp),
    .S_AXI_RVALID                  (rvalid),
    .S_AXI_RREADY                  (rready),
    .ext_bank1_rd_index            (b1_index),
    .ext_bank1_rd_src_addr         (b1_src_addr),
    .ext_bank1_rd_src_size         (b1_src_size),
    .ext_bank1_rd_des_addr         (b1_des_addr),
    .ext_bank1_rd_des_size         (b1_des_size),
    .ext_bank1_rd_status           (b1_status),
    .ext_bank1_rd_profile          (b1_profile),
    .ext_bank1_rd_ld_mask          (b1_ld_mask),
    .ext_bank1_rd_st_mask          (b1_st_mask),
    .ext_bank1_rd_st_intr_mask_abs (b1_st_intr),
    .ext_bank0_rd_control          (b0_control),
    .ext_bank0_rd_status           (b0_status),
    .ext_bank0_rd_curCnt           (b0_cur_cnt),
    .ext_bank0_rd_endCnt           (b0_end_cnt),
    .ext_bank0_rd_dmaBaseAddr      (b0_dma),
    .ext_bank0_rd_dfxCtrlAddr      (b0_dfx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AR handshake at edge N, RVALID seen after edge N+1, RREADY retires it at edge N+2
  task automatic do_read(input string tag, input logic [15:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    n = 0;
    while (!arready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_arready_idle"}, 32'(arready), 32'd1);
    araddr  = addr;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check({tag, "_fetch_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_fetch_arready"}, 32'(arready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check({tag, "_done_rvalid"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_read("b0_dma",       16'h0100, 32'hA000_1000, 2'b00);
    do_read("b0_dma_lsb",   16'h0103, 32'hA000_1000, 2'b00);
    do_read("b0_control",   16'h0000, 32'h0000_000A, 2'b00);
    do_read("b0_status",    16'h0040, 32'h0000_000C, 2'b00);
    do_read("b0_curcnt",    16'h0080, 32'h0000_0002, 2'b00);
    do_read("b0_endcnt",    16'h00C0, 32'h0000_0006, 2'b00);
    do_read("b0_dfx",       16'h0140, 32'h5555_AAAA, 2'b00);
    do_read("b1_profile5",  16'h4154, 32'h0000_BEEF, 2'b00);
    check("b1_index5", 32'(b1_index), 32'd5);
    do_read("b1_alias13",   16'h4354, 32'h0000_BEEF, 2'b00);
    check("b1_alias_index", 32'(b1_index), 32'd5);
    do_read("b1_profile3",  16'h40D4, 32'h1000_0003, 2'b00);
    do_read("b1_srcsize2",  16'h4084, 32'h03FF_FFF2, 2'b00);
    do_read("b1_desaddr1",  16'h4048, 32'h3000_0001, 2'b00);
    do_read("b1_status6",   16'h4190, 32'h0000_0002, 2'b00);
    do_read("b1_stintr7",   16'h41E0, 32'h0000_0087, 2'b00);
    do_read("unmap_bank2",  16'h8000, 32'h0000_0000, 2'b10);
    do_read("unmap_b0off6", 16'h0180, 32'h0000_0000, 2'b10);
    do_read("unmap_bank3",  16'hC100, 32'h0000_0000, 2'b10);
    do_read("unmap_b1fld9", 16'h4024, 32'h0000_0000, 2'b10);

    // backpressure: RESP held while bank0 changes and a new AR waits
    b0_dma  = 32'h1111_2222;
    araddr  = 16'h0100;
    arvalid = 1'b1;
    @(posedge clk); #1;
    araddr  = 16'h0040;
    @(posedge clk); #1;
    check("bp_first_rdata", rdata, 32'h1111_2222);
    for (int i = 0; i < 10; i++) begin
      b0_dma = 32'hDEAD_0000 + 32'(i);
      @(posedge clk); #1;
      check("bp_hold_rdata", rdata, 32'h1111_2222);
      check("bp_hold_arready", 32'(arready), 32'd0);
      check("bp_hold_rvalid", 32'(rvalid), 32'd1);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready  = 1'b0;
    arvalid = 1'b0;
    check("bp_release_arready", 32'(arready), 32'd1);
    check("bp_release_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    check("bp_idle_stays", 32'(arready), 32'd1);
    b0_dma = 32'hA000_1000;

    // reset asserted mid-cycle while RESP is pending
    araddr  = 16'h0100;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_rvalid", 32'(rvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    do_read("post_rst_status", 16'h0040, 32'h0000_000C, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
